core_mem_arbiter: RTL and testbench

//  Shares one 16-bit memory bus between a core's instruction-fetch port and its data port.
//  A fetch is 32 bits wide, so the block sequences it as two 16-bit bus beats.

---
 rtl/core_mem_arbiter_if.sv | 67 ++++++
 rtl/core_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - fetch, data and bus signal bundle for core_mem_arbiter
//
// Purpose: groups the core fetch port, core data port and wishbone-style bus
//          port of the memory arbiter.
// Ports (arbiter view, modport slave):
//   fetch : i_ireq, i_iaddr, i_iaddr_high, i_ilong, i_iflush -> o_idata, o_ivalid, o_iexception
//   data  : i_dreq, i_dwe, i_dlong, i_daddr, i_ddata, i_dsel, i_daddr_high
//           -> o_ddata, o_dack, o_dexception
//   bus   : o_bus_cyc, o_bus_stb, o_bus_we, o_bus_long, o_bus_addr, o_bus_addr_high,
//           o_bus_data, o_bus_sel <- i_bus_data, i_bus_ack, i_bus_err
// modport master is the core/interconnect side of the same signals.
interface core_mem_arbiter_if #(
  parameter int RW     = 16,
  parameter int I_SIZE = 2 * RW
);
  logic              i_ireq;
  logic [RW-1:0]     i_iaddr;
  logic [7:0]        i_iaddr_high;
  logic              i_ilong;
  logic              i_iflush;
  logic [I_SIZE-1:0] o_idata;
  logic              o_ivalid;
  logic              o_iexception;

  logic              i_dreq;
  logic              i_dwe;
  logic              i_dlong;
  logic [RW-1:0]     i_daddr;
  logic [RW-1:0]     i_ddata;
  logic [1:0]        i_dsel;
  logic [7:0]        i_daddr_high;
  logic [RW-1:0]     o_ddata;
  logic              o_dack;
  logic              o_dexception;

  logic              o_bus_cyc;
  logic              o_bus_stb;
  logic              o_bus_we;
  logic              o_bus_long;
  logic [RW-1:0]     o_bus_addr;
  logic [7:0]        o_bus_addr_high;
  logic [RW-1:0]     o_bus_data;
  logic [1:0]        o_bus_sel;
  logic [RW-1:0]     i_bus_data;
  logic              i_bus_ack;
  logic              i_bus_err;

  modport slave (
    input  i_ireq, i_iaddr, i_iaddr_high, i_ilong, i_iflush,
    output o_idata, o_ivalid, o_iexception,
    input  i_dreq, i_dwe, i_dlong, i_daddr, i_ddata, i_dsel, i_daddr_high,
    output o_ddata, o_dack, o_dexception,
    output o_bus_cyc, o_bus_stb, o_bus_we, o_bus_long, o_bus_addr, o_bus_addr_high,
    output o_bus_data, o_bus_sel,
    input  i_bus_data, i_bus_ack, i_bus_err
  );

  modport master (
    output i_ireq, i_iaddr, i_iaddr_high, i_ilong, i_iflush,
    input  o_idata, o_ivalid, o_iexception,
    output i_dreq, i_dwe, i_dlong, i_daddr, i_ddata, i_dsel, i_daddr_high,
    input  o_ddata, o_dack, o_dexception,
    input  o_bus_cyc, o_bus_stb, o_bus_we, o_bus_long, o_bus_addr, o_bus_addr_high,
    input  o_bus_data, o_bus_sel,
    output i_bus_data, i_bus_ack, i_bus_err
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one 16-bit bus between a core's fetch and data ports
//
// Purpose: arbitrates fetch and data requests onto a single wishbone-style bus.
//          Data wins by default; a starvation counter forces a fetch grant after
//          MAX_STARVE consecutive data grants. A 32-bit fetch is two 16-bit beats.
//          Timeouts and bus errors end the transaction with an exception pulse.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous reset, active-high
//   io     core_mem_arbiter_if.slave (fetch port, data port, bus port)
module core_mem_arbiter #(
  parameter int RW         = 16,
  parameter int I_SIZE     = 2 * RW,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input logic               i_clk,
  input logic               i_rst,
  core_mem_arbiter_if.slave io
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, I_LO, I_HI} state_t;

  state_t            r_state, w_state;
  logic [SW-1:0]     r_starve, w_starve;
  logic [TW-1:0]     r_tmo, w_tmo;
  logic              r_kill, w_kill_nxt;
  logic [RW-1:0]     r_ilo, w_ilo;

  logic              r_cyc, w_cyc;
  logic              r_stb, w_stb;
  logic              r_we, w_we;
  logic              r_long, w_long;
  logic [RW-1:0]     r_addr, w_addr;
  logic [7:0]        r_addr_high, w_addr_high;
  logic [RW-1:0]     r_wdata, w_wdata;
  logic [1:0]        r_sel, w_sel;

  logic [I_SIZE-1:0] r_idata, w_idata;
  logic              r_ivalid, w_ivalid;
  logic              r_iexc, w_iexc;
  logic [RW-1:0]     r_ddata, w_ddata;
  logic              r_dack, w_dack;
  logic              r_dexc, w_dexc;

  logic              w_data_wins, w_grant_d, w_grant_i;
  logic              w_ack, w_abort, w_stall, w_killed, w_end;
  logic [RW-1:0]     w_ilo_addr, w_ihi_addr;
  logic [7:0]        w_iaddr_high, w_daddr_high;
  logic              w_unused_ihigh;

  assign w_unused_ihigh = io.i_iaddr_high[7];

  // A held request must not be regranted in the cycle its completion pulse is
  // visible. When data would win but is blocked by o_dack, nothing is granted,
  // so a continuously held fetch still waits for the starvation limit.
  assign w_data_wins = io.i_dreq && !(io.i_ireq && r_starve == STARVE_MAX);
  assign w_grant_d   = w_data_wins && !r_dack;
  assign w_grant_i   = io.i_ireq && !w_data_wins && !r_ivalid;

  // The fetch address counts 32-bit words; the beat address counts 16-bit words.
  // The bit shifted out of i_iaddr always lands in addr_high[0] so short fetches
  // above 0x7FFF do not alias; i_iaddr_high contributes only when long.
  assign w_ilo_addr    = {io.i_iaddr[RW-2:0], 1'b0};
  assign w_ihi_addr    = {io.i_iaddr[RW-2:0], 1'b1};
  assign w_iaddr_high  = {io.i_ilong ? io.i_iaddr_high[6:0] : 7'd0, io.i_iaddr[RW-1]};
  assign w_daddr_high  = io.i_dlong ? io.i_daddr_high : 8'd0;

  // Beat outcome; err beats ack in the same cycle. Only strobed cycles count.
  assign w_ack    = r_stb && io.i_bus_ack && !io.i_bus_err;
  assign w_stall  = r_stb && !io.i_bus_ack && !io.i_bus_err;
  assign w_abort  = (r_stb && io.i_bus_err) || (w_stall && r_tmo == TMO_LAST);
  assign w_killed = r_kill || io.i_iflush;

  always_comb begin
    w_state     = r_state;
    w_starve    = r_starve;
    w_tmo       = r_tmo;
    w_kill_nxt  = r_kill;
    w_ilo       = r_ilo;
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_we        = r_we;
    w_long      = r_long;
    w_addr      = r_addr;
    w_addr_high = r_addr_high;
    w_wdata     = r_wdata;
    w_sel       = r_sel;
    w_idata     = r_idata;
    w_ivalid    = 1'b0;
    w_iexc      = 1'b0;
    w_ddata     = r_ddata;
    w_dack      = 1'b0;
    w_dexc      = 1'b0;
    w_end       = 1'b0;

    if (w_stall) w_tmo = r_tmo + 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state     = DATA;
          w_tmo       = '0;
          w_cyc       = 1'b1;
          w_stb       = 1'b1;
          w_we        = io.i_dwe;
          w_long      = io.i_dlong;
          w_addr      = io.i_daddr;
          w_addr_high = w_daddr_high;
          w_wdata     = io.i_ddata;
          w_sel       = io.i_dsel;
          if (io.i_ireq && r_starve != STARVE_MAX) w_starve = r_starve + 1'b1;
        end else if (w_grant_i) begin
          w_state     = I_LO;
          w_tmo       = '0;
          w_starve    = '0;
          w_kill_nxt  = 1'b0;
          w_cyc       = 1'b1;
          w_stb       = 1'b1;
          w_we        = 1'b0;
          w_long      = io.i_ilong;
          w_addr      = w_ilo_addr;
          w_addr_high = w_iaddr_high;
          w_wdata     = '0;
          w_sel       = 2'b11;
        end
      end
      DATA: begin
        if (w_abort) begin
          w_dack  = 1'b1;
          w_dexc  = 1'b1;
          w_ddata = '0;
          w_end   = 1'b1;
        end else if (w_ack) begin
          w_dack  = 1'b1;
          w_ddata = io.i_bus_data;
          w_end   = 1'b1;
        end
      end
      I_LO: begin
        w_kill_nxt = w_killed;
        if (w_abort) begin
          w_end = 1'b1;
          if (!w_killed) begin
            w_ivalid = 1'b1;
            w_iexc   = 1'b1;
            w_idata  = '0;
          end
        end else if (w_ack) begin
          // One idle strobe cycle separates the beats; cyc is kept asserted.
          w_ilo   = io.i_bus_data;
          w_stb   = 1'b0;
          w_addr  = w_ihi_addr;
          w_tmo   = '0;
          w_state = I_HI;
        end
      end
      I_HI: begin
        w_kill_nxt = w_killed;
        if (!r_stb) w_stb = 1'b1;
        if (w_abort) begin
          w_end = 1'b1;
          if (!w_killed) begin
            w_ivalid = 1'b1;
            w_iexc   = 1'b1;
            w_idata  = '0;
          end
        end else if (w_ack) begin
          w_end = 1'b1;
          if (!w_killed) begin
            w_ivalid = 1'b1;
            w_idata  = {io.i_bus_data, r_ilo};
          end
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_end) begin
      w_state     = IDLE;
      w_cyc       = 1'b0;
      w_stb       = 1'b0;
      w_we        = 1'b0;
      w_long      = 1'b0;
      w_addr      = '0;
      w_addr_high = '0;
      w_wdata     = '0;
      w_sel       = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_tmo       <= '0;
      r_kill      <= 1'b0;
      r_ilo       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_long      <= 1'b0;
      r_addr      <= '0;
      r_addr_high <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_idata     <= '0;
      r_ivalid    <= 1'b0;
      r_iexc      <= 1'b0;
      r_ddata     <= '0;
      r_dack      <= 1'b0;
      r_dexc      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_starve    <= w_starve;
      r_tmo       <= w_tmo;
      r_kill      <= w_kill_nxt;
      r_ilo       <= w_ilo;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_long      <= w_long;
      r_addr      <= w_addr;
      r_addr_high <= w_addr_high;
      r_wdata     <= w_wdata;
      r_sel       <= w_sel;
      r_idata     <= w_idata;
      r_ivalid    <= w_ivalid;
      r_iexc      <= w_iexc;
      r_ddata     <= w_ddata;
      r_dack      <= w_dack;
      r_dexc      <= w_dexc;
    end
  end

  assign io.o_bus_cyc       = r_cyc;
  assign io.o_bus_stb       = r_stb;
  assign io.o_bus_we        = r_we;
  assign io.o_bus_long      = r_long;
  assign io.o_bus_addr      = r_addr;
  assign io.o_bus_addr_high = r_addr_high;
  assign io.o_bus_data      = r_wdata;
  assign io.o_bus_sel       = r_sel;
  assign io.o_idata         = r_idata;
  assign io.o_ivalid        = r_ivalid;
  assign io.o_iexception    = r_iexc;
  assign io.o_ddata         = r_ddata;
  assign io.o_dack          = r_dack;
  assign io.o_dexception    = r_dexc;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   ivalid_cnt;

  core_mem_arbiter_if #(.RW(16)) mif ();

  core_mem_arbiter #(
    .RW(16), .I_SIZE(32), .MAX_STARVE(4), .TIMEOUT(255)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io   (mif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mif.o_ivalid) ivalid_cnt++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a strobed beat, holds it for 'stb_cycles' strobe cycles and
  // answers in the last one with ack or err. Returns after the answering edge.
  task automatic beat(input int stb_cycles, input logic [15:0] rdata, input logic use_err,
                      output logic [15:0] a, output logic [7:0] ah);
    int n;
    n = 0;
    while (!mif.o_bus_stb && n < 50) begin
      tick();
      n++;
    end
    check("beat_stb_seen", mif.o_bus_stb, 1'b1);
    a  = mif.o_bus_addr;
    ah = mif.o_bus_addr_high;
    repeat (stb_cycles - 1) tick();
    mif.i_bus_data = rdata;
    mif.i_bus_ack  = !use_err;
    mif.i_bus_err  = use_err;
    tick();
    mif.i_bus_ack  = 1'b0;
    mif.i_bus_err  = 1'b0;
    mif.i_bus_data = '0;
  endtask

  logic [15:0] a;
  logic [7:0]  ah;
  logic [9:0]  grants;
  int          n, v0;
  logic        saw_stb;

  initial begin
    clk = 1'b0; rst = 1'b1;
    n_checks = 0; n_fails = 0; ivalid_cnt = 0;
    mif.i_ireq = 0; mif.i_iaddr = '0; mif.i_iaddr_high = '0; mif.i_ilong = 0; mif.i_iflush = 0;
    mif.i_dreq = 0; mif.i_dwe = 0; mif.i_dlong = 0; mif.i_daddr = '0; mif.i_ddata = '0;
    mif.i_dsel = '0; mif.i_daddr_high = '0;
    mif.i_bus_data = '0; mif.i_bus_ack = 0; mif.i_bus_err = 0;
    repeat (3) tick();
    check("rst_cyc", mif.o_bus_cyc, 1'b0);
    check("rst_dack", mif.o_dack, 1'b0);
    check("rst_ivalid", mif.o_ivalid, 1'b0);
    check("rst_addr", mif.o_bus_addr, 16'h0);
    rst = 1'b0;
    tick();

    // Data read at 0x0120, ack in the third cyc cycle.
    mif.i_dreq = 1; mif.i_dwe = 0; mif.i_daddr = 16'h0120; mif.i_dsel = 2'b11;
    tick();
    check("d_cyc1", {mif.o_bus_cyc, mif.o_bus_stb, mif.o_bus_we}, 3'b110);
    check("d_addr", mif.o_bus_addr, 16'h0120);
    check("d_ahigh_short", mif.o_bus_addr_high, 8'h00);
    tick();
    check("d_cyc2", mif.o_bus_cyc, 1'b1);
    tick();
    check("d_cyc3", mif.o_bus_cyc, 1'b1);
    mif.i_bus_data = 16'hBEEF; mif.i_bus_ack = 1;
    tick();
    mif.i_bus_ack = 0; mif.i_bus_data = '0;
    check("d_dack", {mif.o_dack, mif.o_dexception, mif.o_bus_cyc}, 3'b100);
    check("d_rdata", mif.o_ddata, 16'hBEEF);
    mif.i_dreq = 0;
    tick();
    check("d_dack_pulse", mif.o_dack, 1'b0);

    // Long data write: high address and write fields pass through.
    mif.i_dreq = 1; mif.i_dwe = 1; mif.i_dlong = 1; mif.i_daddr = 16'h0777;
    mif.i_daddr_high = 8'h5C; mif.i_ddata = 16'hA5C3; mif.i_dsel = 2'b10;
    tick();
    check("dl_fields", {mif.o_bus_we, mif.o_bus_long, mif.o_bus_addr_high, mif.o_bus_sel},
          {1'b1, 1'b1, 8'h5C, 2'b10});
    check("dl_wdata", mif.o_bus_data, 16'hA5C3);
    beat(1, 16'h0, 1'b0, a, ah);
    check("dl_dack", mif.o_dack, 1'b1);
    mif.i_dreq = 0; mif.i_dlong = 0; mif.i_daddr_high = '0;
    tick();

    // Fetch at 0x8004, short addressing.
    v0 = ivalid_cnt;
    mif.i_ireq = 1; mif.i_iaddr = 16'h8004; mif.i_ilong = 0; mif.i_iaddr_high = 8'hAB;
    beat(2, 16'h1111, 1'b0, a, ah);
    check("f_lo_addr", {ah, a}, {8'h01, 16'h0008});
    check("f_gap", {mif.o_bus_cyc, mif.o_bus_stb}, 2'b10);
    beat(1, 16'h2222, 1'b0, a, ah);
    check("f_hi_addr", {ah, a}, {8'h01, 16'h0009});
    check("f_ivalid", {mif.o_ivalid, mif.o_iexception}, 2'b10);
    check("f_idata", mif.o_idata, 32'h2222_1111);
    mif.i_ireq = 0;
    repeat (2) tick();
    check("f_one_pulse", ivalid_cnt - v0, 1);

    // Both requests held: D,D,D,D,I,D,D,D,D,I.
    mif.i_dreq = 1; mif.i_dwe = 0; mif.i_dsel = 2'b01; mif.i_daddr = 16'h0200;
    mif.i_ireq = 1; mif.i_iaddr = 16'h0040;
    grants = '0;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!mif.o_bus_stb && n < 20) begin
        tick();
        n++;
      end
      if (mif.o_bus_sel == 2'b11) begin
        grants[g] = 1'b1;
        beat(1, 16'h0, 1'b0, a, ah);
        beat(1, 16'h0, 1'b0, a, ah);
      end else begin
        beat(1, 16'h0, 1'b0, a, ah);
      end
    end
    mif.i_dreq = 0; mif.i_ireq = 0;
    check("starve_order", grants, 10'b10000_10000);
    repeat (2) tick();

    // Flush during I_HI; long fetch addressing.
    v0 = ivalid_cnt;
    mif.i_ireq = 1; mif.i_iaddr = 16'h0010; mif.i_ilong = 1; mif.i_iaddr_high = 8'h12;
    beat(1, 16'h3333, 1'b0, a, ah);
    check("fl_lo_addr", {ah, a}, {8'h24, 16'h0020});
    mif.i_iflush = 1;
    tick();
    mif.i_iflush = 0;
    beat(2, 16'h4444, 1'b0, a, ah);
    check("fl_hi_addr", a, 16'h0021);
    check("fl_no_valid", mif.o_ivalid, 1'b0);
    mif.i_ireq = 0; mif.i_ilong = 0; mif.i_iaddr_high = '0;
    mif.i_dreq = 1; mif.i_dwe = 0; mif.i_daddr = 16'h0300; mif.i_dsel = 2'b11;
    beat(1, 16'h5A5A, 1'b0, a, ah);
    check("fl_next_data", {mif.o_dack, mif.o_ddata}, {1'b1, 16'h5A5A});
    mif.i_dreq = 0;
    tick();
    check("fl_valid_count", ivalid_cnt - v0, 0);

    // Unacknowledged data write times out after 255 cycles.
    mif.i_dreq = 1; mif.i_dwe = 1; mif.i_daddr = 16'h0042; mif.i_ddata = 16'h1234;
    tick();
    n = 0;
    while (mif.o_bus_cyc && n < 400) begin
      n++;
      tick();
    end
    check("tmo_cycles", n, 255);
    check("tmo_dack", {mif.o_dack, mif.o_dexception}, 2'b11);
    check("tmo_data0", mif.o_ddata, 16'h0);
    mif.i_dreq = 0; mif.i_dwe = 0;
    tick();
    check("tmo_exc_clear", {mif.o_dack, mif.o_dexception}, 2'b00);

    // Bus error on the low fetch beat: exception, no high beat.
    mif.i_ireq = 1; mif.i_iaddr = 16'h0100;
    beat(1, 16'hFFFF, 1'b1, a, ah);
    check("ierr_pulse", {mif.o_ivalid, mif.o_iexception, mif.o_bus_cyc}, 3'b110);
    check("ierr_data0", mif.o_idata, 32'h0);
    mif.i_ireq = 0;
    saw_stb = 0;
    repeat (3) begin
      tick();
      saw_stb = saw_stb | mif.o_bus_stb;
    end
    check("ierr_no_hi", saw_stb, 1'b0);

    // Reset while in I_HI; the held fetch restarts from the low beat.
    mif.i_ireq = 1; mif.i_iaddr = 16'h0003;
    beat(1, 16'h7777, 1'b0, a, ah);
    tick();
    check("r_in_hi", {mif.o_bus_cyc, mif.o_bus_stb, mif.o_bus_addr}, {2'b11, 16'h0007});
    #2 rst = 1;
    #1;
    check("r_async", {mif.o_bus_cyc, mif.o_bus_stb, mif.o_bus_addr, mif.o_idata},
          {2'b00, 16'h0, 32'h0});
    tick();
    rst = 0;
    tick();
    check("r_restart", {mif.o_bus_stb, mif.o_bus_addr}, {1'b1, 16'h0006});
    beat(1, 16'h0A0A, 1'b0, a, ah);
    beat(1, 16'h0B0B, 1'b0, a, ah);
    check("r_idata", {mif.o_ivalid, mif.o_idata}, {1'b1, 32'h0B0B_0A0A});
    mif.i_ireq = 0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
